// File: rtl/register_file_16x16.sv
// register_file_16x16 -- 16 x 16-bit architectural register file for the WISC core.
//
// Two asynchronous read ports and one synchronous write port. R0 is hardwired to zero.
// Reads use one-hot wordlines from two always-enabled 4->16 read decoders feeding AND-OR
// bitlines; writes use a 4->16 decoder gated by WriteReg.
//
// Optional build macro: RF_BYPASS_EN
//   defined   : a write to register N is forwarded combinationally to any read port
//               addressing N in the same cycle (qualified by WriteReg, !rst, DstReg != 0).
//   undefined : a colliding read returns the old value; there is no path DstData -> SrcDataN.
//
// Ports:
//   clk      in   core clock, rising-edge state updates
//   rst      in   synchronous active-high reset, clears all entries, beats a write
//   SrcReg1  in   [3:0]  read port 1 register ID
//   SrcReg2  in   [3:0]  read port 2 register ID
//   DstReg   in   [3:0]  write port register ID
//   WriteReg in   write enable
//   DstData  in   [15:0] write data
//   SrcData1 out  [15:0] read port 1 data
//   SrcData2 out  [15:0] read port 2 data

module register_file_16x16 #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16  // must stay 16 to match 4-bit register IDs
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        SrcReg1,
    input  logic [3:0]        SrcReg2,
    input  logic [3:0]        DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_wl;
    logic [NUM_REGS-1:0] rd1_wl;
    logic [NUM_REGS-1:0] rd2_wl;
    logic [DATA_W-1:0]   rd1_data;
    logic [DATA_W-1:0]   rd2_data;

    // Decoders. The write wordline for R0 is forced low so R0 can never be written.
    always_comb begin
        wr_wl          = '0;
        rd1_wl         = '0;
        rd2_wl         = '0;
        wr_wl[DstReg]  = WriteReg;
        wr_wl[0]       = 1'b0;
        rd1_wl[SrcReg1] = 1'b1;
        rd2_wl[SrcReg2] = 1'b1;
    end

    // Storage. Reset clears every entry and takes priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_wl[i]) begin
                    regs_q[i] <= DstData;
                end
            end
        end
    end

    // AND-OR bitlines. Entry 0 is left off the bitlines, so an ID-0 read drives zero
    // regardless of flop contents; the other terms are each gated by their wordline.
    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rd1_data = rd1_data | (regs_q[i] & {DATA_W{rd1_wl[i]}});
            rd2_data = rd2_data | (regs_q[i] & {DATA_W{rd2_wl[i]}});
        end
    end

`ifdef RF_BYPASS_EN
    logic wr_live;
    logic fwd1;
    logic fwd2;

    // A write only forwards if it would actually land in the array at the next edge.
    assign wr_live  = WriteReg && !rst && (DstReg != 4'h0);
    assign fwd1     = wr_live && (DstReg == SrcReg1);
    assign fwd2     = wr_live && (DstReg == SrcReg2);
    assign SrcData1 = fwd1 ? DstData : rd1_data;
    assign SrcData2 = fwd2 ? DstData : rd2_data;
`else
    assign SrcData1 = rd1_data;
    assign SrcData2 = rd2_data;
`endif

endmodule

// File: tb/tb_register_file_16x16.sv
module tb_register_file_16x16;

    logic        clk;
    logic        rst;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    int vectors;
    int miscompares;

    register_file_16x16 dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs on the falling edge; outputs are sampled 1 time unit later,
    // well before the next rising edge commits the write.
    task automatic drive(input logic r, input logic we, input logic [3:0] dst,
                         input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2);
        @(negedge clk);
        rst      = r;
        WriteReg = we;
        DstReg   = dst;
        DstData  = data;
        SrcReg1  = s1;
        SrcReg2  = s2;
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_coll;
        logic [3:0]  id;
        logic [3:0]  rid;

        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        WriteReg    = 1'b0;
        DstReg      = 4'h0;
        DstData     = 16'h0000;
        SrcReg1     = 4'h0;
        SrcReg2     = 4'h0;

        // Initial reset, then check cleared state.
        drive(1'b1, 1'b0, 4'h0, 16'h0000, 4'h3, 4'h9);
        drive(1'b0, 1'b1, 4'h5, 16'hBEEF, 4'h3, 4'h9);
        check("reset_clear_p1", SrcData1, 16'h0000);
        check("reset_clear_p2", SrcData2, 16'h0000);

        // R5 = BEEF, then reset with a simultaneous write of 1234 to R5.
        drive(1'b1, 1'b1, 4'h5, 16'h1234, 4'h5, 4'h5);
        check("rst_same_cycle_no_fwd", SrcData1, 16'hBEEF);
        drive(1'b0, 1'b0, 4'h5, 16'h1234, 4'h5, 4'h5);
        check("reset_drops_write", SrcData1, 16'h0000);

        // First write after reset behaves normally.
        drive(1'b0, 1'b1, 4'h9, 16'h9999, 4'h0, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 4'h9, 4'h5);
        check("post_reset_write", SrcData1, 16'h9999);
        check("post_reset_other", SrcData2, 16'h0000);

        // Basic write/read, plus other registers untouched.
        drive(1'b0, 1'b1, 4'h1, 16'h00A5, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 4'hF, 16'hFFFF, 4'h0, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 4'h1, 4'hF);
        check("basic_r1", SrcData1, 16'h00A5);
        check("basic_r15", SrcData2, 16'hFFFF);
        for (int i = 2; i < 15; i++) begin
            if (i != 9) begin
                id = i[3:0];
                drive(1'b0, 1'b0, 4'h0, 16'h0000, id, id);
                check("basic_others_p1", SrcData1, 16'h0000);
                check("basic_others_p2", SrcData2, 16'h0000);
            end
        end

        // R0 hardwired zero, same cycle and next cycle.
        drive(1'b0, 1'b1, 4'h0, 16'h5555, 4'h0, 4'h0);
        check("r0_same_cycle", SrcData1, 16'h0000);
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 4'h0, 4'h0);
        check("r0_next_cycle", SrcData1, 16'h0000);

        // Collision on R3.
        drive(1'b0, 1'b1, 4'h3, 16'h1111, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 4'h3, 16'h2222, 4'h3, 4'h3);
`ifdef RF_BYPASS_EN
        exp_coll = 16'h2222;
`else
        exp_coll = 16'h1111;
`endif
        check("coll_same_p1", SrcData1, exp_coll);
        check("coll_same_p2", SrcData2, exp_coll);
        drive(1'b0, 1'b0, 4'h3, 16'h0000, 4'h3, 4'h3);
        check("coll_next_p1", SrcData1, 16'h2222);
        check("coll_next_p2", SrcData2, 16'h2222);

        // Write disable: R7 must stay zero and see no forwarding.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 4'h7, 16'hDEAD, 4'h7, 4'h7);
            check("wdis_r7", SrcData1, 16'h0000);
        end
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 4'h7, 4'h7);
        check("wdis_r7_after", SrcData1, 16'h0000);

        // Sweep: entry i = {4{i}}, read all IDs with port 2 reversed.
        for (int i = 1; i < 16; i++) begin
            id = i[3:0];
            drive(1'b0, 1'b1, id, {4{id}}, 4'h0, 4'h0);
        end
        for (int i = 0; i < 16; i++) begin
            id  = i[3:0];
            rid = 4'(15 - i);
            drive(1'b0, 1'b0, 4'h0, 16'h0000, id, rid);
            check("sweep_p1", SrcData1, (id == 4'h0) ? 16'h0000 : {4{id}});
            check("sweep_p2", SrcData2, (rid == 4'h0) ? 16'h0000 : {4{rid}});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
